fft32_frame_loader: RTL and testbench



---
 rtl/fft32_frame_loader.sv | 138 +++++++++++++
 tb/tb_fft32_frame_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_frame_loader.sv
// Serial sign-magnitude sample stream -> ping-pong frame buffer -> packed parallel frame for fft32.
// Optional macro FRAME_SYNC_EN adds s_last framing with a sync_err pulse.
module fft32_frame_loader #(
    parameter int N       = 32,
    parameter int DW      = 24,
    parameter int FFT_LAT = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
`ifdef FRAME_SYNC_EN
    input  logic            s_last,
    output logic            sync_err,
`endif
    output logic [N*DW-1:0] frame_data,
    output logic            start,
    output logic [7:0]      frame_cnt
);
    localparam int IW = $clog2(N);
    localparam int HW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

    typedef enum logic {WR_FILL, WR_FULL} wr_state_t;
    typedef enum logic {RD_IDLE, RD_HOLD} rd_state_t;

    wr_state_t     wr_state_q, wr_state_d;
    rd_state_t     rd_state_q, rd_state_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [DW-1:0] bank_q [2][N];
    logic [DW-1:0] bank_d [2][N];
    logic          xfer;
    logic          swap;
`ifdef FRAME_SYNC_EN
    logic          sync_err_q, sync_err_d;
`endif

    // Negative zero collapses to +0 so fft32 only ever sees one zero code.
    function automatic logic [DW-1:0] norm_zero(input logic [DW-1:0] x);
        return (x == {1'b1, {(DW-1){1'b0}}}) ? '0 : x;
    endfunction

    assign xfer = s_valid & s_ready;
    assign swap = (wr_state_q == WR_FULL) && (rd_state_q == RD_IDLE);

    always_comb begin
        wr_state_d  = wr_state_q;
        rd_state_d  = rd_state_q;
        widx_d      = widx_q;
        hold_cnt_d  = hold_cnt_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
        bank_d      = bank_q;
`ifdef FRAME_SYNC_EN
        sync_err_d  = 1'b0;
`endif
        // The write side always targets the bank not shown on frame_data.
        if (xfer) begin
            bank_d[~rd_bank_q][widx_q] = norm_zero(s_data);
            if (widx_q == IW'(N-1)) begin
                wr_state_d = WR_FULL;
                widx_d     = '0;
`ifdef FRAME_SYNC_EN
                sync_err_d = ~s_last;
`endif
            end
`ifdef FRAME_SYNC_EN
            else if (s_last) begin
                widx_d     = '0;
                sync_err_d = 1'b1;
            end
`endif
            else begin
                widx_d = widx_q + IW'(1);
            end
        end

        if (swap) begin
            rd_bank_d   = ~rd_bank_q;
            rd_state_d  = RD_HOLD;
            hold_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            wr_state_d  = WR_FILL;
        end else if (rd_state_q == RD_HOLD) begin
            if (hold_cnt_q == HW'(FFT_LAT-1)) begin
                rd_state_d = RD_IDLE;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_state_q  <= WR_FILL;
            rd_state_q  <= RD_IDLE;
            widx_q      <= '0;
            hold_cnt_q  <= '0;
            rd_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
`ifdef FRAME_SYNC_EN
            sync_err_q  <= 1'b0;
`endif
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            widx_q      <= widx_d;
            hold_cnt_q  <= hold_cnt_d;
            rd_bank_q   <= rd_bank_d;
            frame_cnt_q <= frame_cnt_d;
            bank_q      <= bank_d;
`ifdef FRAME_SYNC_EN
            sync_err_q  <= sync_err_d;
`endif
        end
    end

    // Gated by rst_n so handshake and start drop in the very cycle reset is asserted.
    assign s_ready   = (wr_state_q == WR_FILL) & ~rst_n;
    assign start     = (rd_state_q == RD_HOLD) & ~rst_n;
    assign frame_cnt = frame_cnt_q;
`ifdef FRAME_SYNC_EN
    assign sync_err  = sync_err_q;
`endif

    for (genvar k = 0; k < N; k++) begin : g_frame
        assign frame_data[k*DW +: DW] = bank_q[rd_bank_q][k];
    end

endmodule

// File: tb/tb_fft32_frame_loader.sv
// Bench for fft32_frame_loader: directed and random sample streams checked against a
// frame-level reference model. Define FRAME_SYNC_EN to also cover s_last/sync_err.
module tb_fft32_frame_loader;
    localparam int N       = 32;
    localparam int DW      = 24;
    localparam int FFT_LAT = 6;
    localparam int FW      = N*DW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data  = '0;
    logic [FW-1:0] frame_data;
    logic          start;
    logic [7:0]    frame_cnt;
`ifdef FRAME_SYNC_EN
    logic          s_last  = 1'b0;
    logic          sync_err;
    bit            sync_exp = 1'b0;
`endif

    fft32_frame_loader #(.N(N), .DW(DW), .FFT_LAT(FFT_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
`ifdef FRAME_SYNC_EN
        .s_last     (s_last),
        .sync_err   (sync_err),
`endif
        .frame_data (frame_data),
        .start      (start),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: samples of the frame being collected, the completed frame waiting
    // for the read side, the frame expected on frame_data, and edge numbers of swaps.
    logic [DW-1:0] cur[$];
    logic [DW-1:0] pend_frame[N];
    logic [DW-1:0] shown[N];
    bit            pend      = 1'b0;
    int            edge_n    = 0;
    int            cur_swap  = -1000;
    int            next_swap = 0;
    int            cnt_exp   = 0;
    int            run       = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [FW-1:0] exp_fd;
        for (int k = 0; k < N; k++) exp_fd[k*DW +: DW] = shown[k];
        check("s_ready", FW'(s_ready), FW'(!rst_n && !pend));
        check("start", FW'(start),
              FW'(!rst_n && edge_n >= cur_swap && edge_n < cur_swap + FFT_LAT));
        check("frame_cnt", FW'(frame_cnt), FW'(cnt_exp));
        check("frame_data", frame_data, exp_fd);
`ifdef FRAME_SYNC_EN
        check("sync_err", FW'(sync_err), FW'(sync_exp));
`endif
        if (start) begin
            run++;
        end else begin
            if (run > 0 && !rst_n) check("start_width", FW'(run), FW'(FFT_LAT));
            run = 0;
        end
    endtask

    // One clock: note what the edge will see, advance the model, check outputs on the falling edge.
    task automatic tick();
        bit            xf;
        bit            rs;
        logic [DW-1:0] d;
`ifdef FRAME_SYNC_EN
        bit            lst;
        lst = s_last;
`endif
        rs = rst_n;
        d  = s_data;
        xf = s_valid && !rst_n && !pend;
        @(posedge clk);
        edge_n++;
`ifdef FRAME_SYNC_EN
        sync_exp = 1'b0;
`endif
        if (rs) begin
            cur.delete();
            pend     = 1'b0;
            cur_swap = -1000;
            cnt_exp  = 0;
            for (int k = 0; k < N; k++) shown[k] = '0;
        end else begin
            if (pend && edge_n == next_swap) begin
                shown    = pend_frame;
                cnt_exp  = (cnt_exp + 1) % 256;
                cur_swap = next_swap;
                pend     = 1'b0;
            end
            if (xf) begin
                cur.push_back((d == 24'h800000) ? '0 : d);
                if (cur.size() == N) begin
                    for (int k = 0; k < N; k++) pend_frame[k] = cur[k];
                    cur.delete();
                    pend      = 1'b1;
                    next_swap = ((edge_n > cur_swap + FFT_LAT) ? edge_n : cur_swap + FFT_LAT) + 1;
`ifdef FRAME_SYNC_EN
                    sync_exp = !lst;
`endif
                end
`ifdef FRAME_SYNC_EN
                else if (lst) begin
                    cur.delete();
                    sync_exp = 1'b1;
                end
`endif
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data = DW'($urandom);
            tick();
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        rst_n   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        bit will;
        if (gap > 0) idle(gap);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 64; i++) begin
            will = !pend && !rst_n;
            tick();
            if (will) return;
        end
        check("send_timeout", FW'(0), FW'(1));
    endtask

    initial begin
        // Reset and the first cycle after it.
        do_reset();
        tick();
        check("rst_ready", FW'(s_ready), FW'(1));
        check("rst_start", FW'(start), FW'(0));
        check("rst_cnt", FW'(frame_cnt), FW'(0));
        check("rst_fd", frame_data, FW'(0));

        // Single frame: 2.0 in slots 0-2, zero elsewhere.
        for (int k = 0; k < N; k++) send((k < 3) ? 24'h000800 : 24'h000000, 0);
        idle(10);
        check("single_s0", FW'(frame_data[0 +: DW]), FW'(24'h000800));
        check("single_s2", FW'(frame_data[2*DW +: DW]), FW'(24'h000800));
        check("single_s3", FW'(frame_data[3*DW +: DW]), FW'(0));
        check("single_cnt", FW'(frame_cnt), FW'(1));

        // Back-to-back frames A then ramp B.
        do_reset();
        for (int k = 0; k < N; k++) send((k == 0) ? 24'h000800 : 24'h000000, 0);
        for (int k = 0; k < N; k++) send(DW'(24'h000400 * k), 0);
        idle(12);
        check("b2b_s5", FW'(frame_data[5*DW +: DW]), FW'(24'h001400));
        check("b2b_s31", FW'(frame_data[31*DW +: DW]), FW'(24'h007C00));
        check("b2b_cnt", FW'(frame_cnt), FW'(2));

        // Negative zero and a negative value.
        do_reset();
        send(24'h800000, 0);
        send(24'h800C00, 0);
        for (int k = 2; k < N; k++) send(DW'($urandom), 0);
        idle(10);
        check("negzero", FW'(frame_data[0 +: DW]), FW'(0));
        check("neg3", FW'(frame_data[DW +: DW]), FW'(24'h800C00));

        // Reset in the middle of a fill.
        do_reset();
        for (int k = 0; k < 17; k++) send(DW'($urandom), $urandom_range(0, 1));
        do_reset();
        for (int k = 0; k < N; k++) send(24'h000400, 0);
        idle(10);
        for (int k = 0; k < N; k++) check("midfill_slot", FW'(frame_data[k*DW +: DW]), FW'(24'h000400));
        check("midfill_cnt", FW'(frame_cnt), FW'(1));

        // Reset in the middle of a hold.
        for (int k = 0; k < N; k++) send(DW'($urandom), 0);
        idle(3);
        do_reset();
        idle(2);
        check("midhold_cnt", FW'(frame_cnt), FW'(0));

        // Random streams long enough to wrap frame_cnt.
        for (int f = 0; f < 260; f++) begin
            for (int k = 0; k < N; k++) begin
                logic [DW-1:0] d;
                d = DW'($urandom);
                if ($urandom_range(0, 7) == 0) d = 24'h800000;
                send(d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
        end
        idle(10);
        check("wrap_cnt", FW'(frame_cnt), FW'(260 % 256));

`ifdef FRAME_SYNC_EN
        // Early s_last discards the partial frame.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            s_last = (k == 9);
            send(DW'($urandom), 0);
        end
        s_last = 1'b0;
        check("sync_pulse", FW'(sync_err), FW'(1));
        idle(8);
        check("sync_nostart_cnt", FW'(frame_cnt), FW'(0));
        for (int k = 0; k < N; k++) begin
            s_last = (k == N-1);
            send(DW'($urandom), 0);
        end
        s_last = 1'b0;
        idle(10);
        check("sync_cnt", FW'(frame_cnt), FW'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
